// File: rtl/track_pkg.sv
// Shared types, default timing constants and round-robin helpers for the
// single-track section arbiter.
package track_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      OCCUPIED,
      ALARM
   } state_t;

   localparam int DEF_DEB_CYCLES     = 4;
   localparam int DEF_SW_SETTLE      = 8;
   localparam int DEF_TIMEOUT_CYCLES = 1024;
   localparam int MAX_TRAINS         = 8;

   // First set bit of req at or after ptr, wrapping modulo n.
   function automatic int rr_pick(input logic [MAX_TRAINS-1:0] req, input int ptr, input int n);
      int   pick;
      int   pos;
      logic found;
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < MAX_TRAINS; k++) begin
         pos = (ptr + k) % n;
         if (k < n && !found && ((req >> pos) & 8'd1) != 8'd0) begin
            pick  = pos;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic int rr_wrap_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer plus consecutive-sample debounce for one raw sensor;
// emits a registered one-cycle pulse on each filtered 0->1 transition.
module sensor_debounce
   import track_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_rise
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_filt;
   logic          r_rise;

   // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
         r_cnt  <= '0;
         r_filt <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_raw};
         r_rise <= 1'b0;
         if (r_sync[1] == r_filt) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
            r_cnt  <= '0;
            r_filt <= r_sync[1];
            r_rise <= r_sync[1];
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_rise = r_rise;

endmodule

// File: rtl/track_section_arbiter.sv
// Round-robin arbiter granting one shared single-track segment to N trains,
// driving the route switch, per-train stop signals and sticky alarm/fault flags.
module track_section_arbiter
   import track_pkg::*;
#(
   parameter int N_TRAINS       = 4,
   parameter int DEB_CYCLES     = DEF_DEB_CYCLES,
   parameter int SW_SETTLE      = DEF_SW_SETTLE,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_TRAINS-1:0]         i_approach,
   input  logic [N_TRAINS-1:0]         i_clear,
   output logic [N_TRAINS-1:0]         o_go,
   output logic [$clog2(N_TRAINS)-1:0] o_sw_sel,
   output logic                        o_busy,
   output logic                        o_alarm,
   output logic                        o_fault
);

   localparam int OW = $clog2(N_TRAINS);
   localparam int SW = $clog2(SW_SETTLE + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [N_TRAINS-1:0] ONE = {{(N_TRAINS - 1){1'b0}}, 1'b1};

   state_t              r_state;
   logic [OW-1:0]       r_owner;
   logic [OW-1:0]       r_rr_ptr;
   logic [N_TRAINS-1:0] r_pending;
   logic [N_TRAINS-1:0] r_go;
   logic [SW-1:0]       r_settle_cnt;
   logic [TW-1:0]       r_to_cnt;
   logic                r_busy;
   logic                r_alarm;
   logic                r_fault;

   logic [N_TRAINS-1:0] w_app_rise;
   logic [N_TRAINS-1:0] w_clr_rise;
   logic [N_TRAINS-1:0] w_owner_oh;
   logic [N_TRAINS-1:0] w_pending_nxt;
   logic [OW-1:0]       w_pick;
   logic                w_owner_clr;
   logic                w_other_clr;

   for (genvar i = 0; i < N_TRAINS; i++) begin : g_sensor
      sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_app (
         .clk    (clk),
         .rst    (rst),
         .i_raw  (i_approach[i]),
         .o_rise (w_app_rise[i])
      );
      sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr (
         .clk    (clk),
         .rst    (rst),
         .i_raw  (i_clear[i]),
         .o_rise (w_clr_rise[i])
      );
   end

   assign w_owner_oh    = ONE << r_owner;
   assign w_owner_clr   = (r_state == OCCUPIED) && ((w_clr_rise & w_owner_oh) != '0);
   assign w_other_clr   = (r_state == SETTLE || r_state == OCCUPIED) &&
                          ((w_clr_rise & ~w_owner_oh) != '0);
   assign w_pending_nxt = (r_pending | w_app_rise) & ~(w_owner_clr ? w_owner_oh : '0);
   assign w_pick        = OW'(rr_pick(8'(r_pending), int'(r_rr_ptr), N_TRAINS));

   // go is computed from next-cycle pending/state so a new request stops its train on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_owner      <= '0;
         r_rr_ptr     <= '0;
         r_pending    <= '0;
         r_go         <= '1;
         r_settle_cnt <= '0;
         r_to_cnt     <= '0;
         r_busy       <= 1'b0;
         r_alarm      <= 1'b0;
         r_fault      <= 1'b0;
      end else begin
         r_pending <= w_pending_nxt;
         if (w_other_clr) r_fault <= 1'b1;
         case (r_state)
            IDLE: begin
               r_go <= ~w_pending_nxt;
               if (r_pending != '0) begin
                  r_owner      <= w_pick;
                  r_settle_cnt <= '0;
                  r_busy       <= 1'b1;
                  r_state      <= SETTLE;
               end
            end
            SETTLE: begin
               if (r_settle_cnt == SW'(SW_SETTLE - 1)) begin
                  r_state  <= OCCUPIED;
                  r_to_cnt <= '0;
                  r_go     <= ~w_pending_nxt | w_owner_oh;
               end else begin
                  r_settle_cnt <= r_settle_cnt + 1'b1;
                  r_go         <= ~w_pending_nxt;
               end
            end
            OCCUPIED: begin
               if (w_owner_clr) begin
                  r_state  <= IDLE;
                  r_busy   <= 1'b0;
                  r_rr_ptr <= OW'(rr_wrap_next(int'(r_owner), N_TRAINS));
                  r_go     <= ~w_pending_nxt;
               end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  r_state  <= ALARM;
                  r_busy   <= 1'b0;
                  r_alarm  <= 1'b1;
                  r_go     <= '0;
                  r_to_cnt <= TW'(TIMEOUT_CYCLES);
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
                  r_go     <= ~w_pending_nxt | w_owner_oh;
               end
            end
            ALARM:   r_go <= '0;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_go     = r_go;
   assign o_sw_sel = r_owner;
   assign o_busy   = r_busy;
   assign o_alarm  = r_alarm;
   assign o_fault  = r_fault;

endmodule

// File: tb/tb_track_section_arbiter.sv
// Directed bench for track_section_arbiter: exact-cycle checks plus a queue of
// expected grant owners/go patterns popped as grants appear.
module tb_track_section_arbiter;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] approach;
   logic [N-1:0] clear;
   logic [N-1:0] go;
   logic [1:0]   sw_sel;
   logic         busy;
   logic         alarm;
   logic         fault;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       tag;
      logic [31:0] v;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   track_section_arbiter #(
      .N_TRAINS       (N),
      .DEB_CYCLES     (4),
      .SW_SETTLE      (8),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_approach (approach),
      .i_clear    (clear),
      .o_go       (go),
      .o_sw_sel   (sw_sel),
      .o_busy     (busy),
      .o_alarm    (alarm),
      .o_fault    (fault)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp_v);
      end
   endtask

   task automatic expect_v(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      sb_q.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      n_tests++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $error("FAIL sb_empty: observed %0h required no output", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.v);
         end
      end
   endtask

   task automatic check_reset(input string p);
      compare({p, "_go"},     32'(go),     32'hF);
      compare({p, "_sw_sel"}, 32'(sw_sel), 0);
      compare({p, "_busy"},   32'(busy),   0);
      compare({p, "_alarm"},  32'(alarm),  0);
      compare({p, "_fault"},  32'(fault),  0);
   endtask

   task automatic do_reset(input string p);
      rst = 1'b1;
      tick(2);
      check_reset(p);
      rst = 1'b0;
      tick(2);
   endtask

   task automatic wait_busy(input logic val, input int budget, input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (busy === val) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
      compare(tag, 32'(ok), 1);
   endtask

   task automatic wait_occ(input logic [1:0] idx, input int budget, input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (busy === 1'b1 && sw_sel === idx && go[idx] === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
      compare(tag, 32'(ok), 1);
   endtask

   // Pops the expected owner and its OCCUPIED go pattern, then releases it.
   task automatic serve_next();
      logic [1:0] own;
      wait_busy(1'b1, 40, "grant_seen");
      check(32'(sw_sel));
      own = sw_sel;
      wait_occ(own, 20, "occ_seen");
      check(32'(go));
      clear[own] = 1'b1;
      wait_busy(1'b0, 20, "release_seen");
      clear[own] = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      approach = '0;
      clear    = '0;
      tick(3);
      check_reset("rst0");
      rst = 1'b0;
      tick(2);

      // Single request from train 2, exact cycle timing.
      approach[2] = 1'b1;
      tick(6);
      compare("t1_go_before", 32'(go), 'hF);
      tick(1);
      compare("t1_go_fall", 32'(go), 'b1011);
      compare("t1_busy_pend", 32'(busy), 0);
      tick(1);
      compare("t1_sw_sel", 32'(sw_sel), 2);
      compare("t1_busy", 32'(busy), 1);
      approach[2] = 1'b0;
      tick(7);
      compare("t1_go_settle", 32'(go), 'b1011);
      tick(1);
      compare("t1_go_rise", 32'(go), 'hF);
      clear[2] = 1'b1;
      tick(6);
      compare("t1_busy_hold", 32'(busy), 1);
      tick(1);
      compare("t1_release", 32'(busy), 0);
      compare("t1_go_after", 32'(go), 'hF);
      clear[2] = 1'b0;
      tick(10);

      // Round-robin among 0, 1, 3; then 0 before a later 1.
      do_reset("rr_rst");
      expect_v("rr_own0", 0);
      expect_v("rr_go0",  'b0101);
      expect_v("rr_own1", 1);
      expect_v("rr_go1",  'b0111);
      expect_v("rr_own3", 3);
      expect_v("rr_go3",  'b1111);
      approach = 4'b1011;
      serve_next();
      serve_next();
      serve_next();
      approach = '0;
      tick(10);
      expect_v("rr2_own0", 0);
      expect_v("rr2_go0",  'b1101);
      expect_v("rr2_own1", 1);
      expect_v("rr2_go1",  'b1111);
      approach[0] = 1'b1;
      tick(2);
      approach[1] = 1'b1;
      serve_next();
      serve_next();
      approach = '0;
      tick(10);

      // Glitch rejection: 3 cycles ignored, 6 cycles accepted.
      approach[1] = 1'b1;
      tick(3);
      approach[1] = 1'b0;
      tick(12);
      compare("gl_go", 32'(go), 'hF);
      compare("gl_busy", 32'(busy), 0);
      expect_v("gl_own1", 1);
      expect_v("gl_go1",  'hF);
      approach[1] = 1'b1;
      tick(6);
      approach[1] = 1'b0;
      serve_next();
      tick(10);

      // Non-owner clear -> fault; owner clear with simultaneous new approach.
      do_reset("f_rst");
      approach[0] = 1'b1;
      wait_occ(2'd0, 30, "f_occ");
      approach[0] = 1'b0;
      clear[2]    = 1'b1;
      tick(6);
      compare("f_fault_pre", 32'(fault), 0);
      tick(1);
      compare("f_fault", 32'(fault), 1);
      compare("f_owner_go", 32'(go), 'hF);
      compare("f_busy", 32'(busy), 1);
      clear[2]    = 1'b0;
      clear[0]    = 1'b1;
      approach[3] = 1'b1;
      wait_busy(1'b0, 12, "f_release");
      compare("f_go_idle", 32'(go), 'b0111);
      compare("f_fault_sticky", 32'(fault), 1);
      compare("f_alarm", 32'(alarm), 0);
      tick(1);
      compare("f_regrant_busy", 32'(busy), 1);
      compare("f_regrant_sel", 32'(sw_sel), 3);
      clear[0]    = 1'b0;
      approach[3] = 1'b0;

      // Asynchronous reset mid-SETTLE with approach held.
      do_reset("r_rst");
      approach[1] = 1'b1;
      wait_busy(1'b1, 20, "r_settle");
      tick(2);
      #2;
      rst = 1'b1;
      #1;
      check_reset("r_async");
      tick(2);
      rst = 1'b0;
      tick(6);
      compare("r_go_before", 32'(go), 'hF);
      tick(1);
      compare("r_go_fall", 32'(go), 'b1101);
      tick(1);
      compare("r_regrant_busy", 32'(busy), 1);
      compare("r_regrant_sel", 32'(sw_sel), 1);
      approach[1] = 1'b0;

      // Timeout: owner never clears.
      do_reset("to_rst");
      approach[2] = 1'b1;
      wait_occ(2'd2, 30, "to_occ");
      compare("to_go_occ", 32'(go), 'hF);
      tick(15);
      compare("to_alarm_pre", 32'(alarm), 0);
      compare("to_go_pre", 32'(go), 'hF);
      tick(1);
      compare("to_alarm", 32'(alarm), 1);
      compare("to_go", 32'(go), 0);
      compare("to_busy", 32'(busy), 0);
      compare("to_sw_sel", 32'(sw_sel), 2);
      approach[2] = 1'b0;
      tick(20);
      compare("to_alarm_held", 32'(alarm), 1);
      compare("to_go_held", 32'(go), 0);
      rst = 1'b1;
      tick(1);
      check_reset("to_clr");
      rst = 1'b0;
      tick(2);

      n_tests++;
      assert (sb_q.size() == 0) else begin
         n_fail++;
         $error("FAIL sb_leftover: observed %0d entries required 0", sb_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/track_section_arbiter.md
# track_section_arbiter

Sequencer and arbiter for one shared single-track segment used by up to N trains. It debounces raw approach and exit sensors and grants the segment to one train at a time, round-robin. It drives the route switch, holds the other trains at their stop signals, and raises a latched alarm if the segment stays occupied too long. It sits between the track sensor inputs and the switch/stop-signal actuators, and generalizes the two-train crossing controller to N requesters.

## Interface
- N_TRAINS, 4: number of requesting trains, 2..8.
- DEB_CYCLES, 4: consecutive stable samples required before a filtered sensor changes.
- SW_SETTLE, 8: cycles allowed for the switch to settle before the owner gets go.
- TIMEOUT_CYCLES, 1024: maximum cycles in OCCUPIED before the alarm fires.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- approach  in  N_TRAINS  raw entry sensors, active-high, asynchronous to clk.
- clear  in  N_TRAINS  raw exit sensors past the shared segment, active-high, asynchronous.
- go  out  N_TRAINS  per-train signal: 1 = proceed, 0 = stop. Registered.
- sw_sel  out  $clog2(N_TRAINS)  route switch position = owner index. Registered.
- busy  out  1  segment granted (SETTLE or OCCUPIED).
- alarm  out  1  timeout; sticky until rst.
- fault  out  1  a non-owner train cleared while the segment was busy; sticky until rst.

## Operation
- Each raw input passes through a 2-flop synchronizer and then a debounce counter.
  - The filtered value changes only after DEB_CYCLES consecutive synchronized samples differ from it.
  - A one-cycle rise pulse is emitted on each filtered 0->1 transition.
- Requests:
  - An approach rise sets pending[i].
  - A rise on an already-pending train is ignored.
  - pending[i] clears only when train i, as owner, produces a clear rise.
- go[i] = 0 when pending[i] = 1 and (i is not the owner or state is not OCCUPIED). Otherwise go[i] = 1, except in ALARM.
- States:
  - IDLE: no owner. If any pending bit is set, pick the first pending index at or after rr_ptr (wrapping modulo N_TRAINS). Latch it as owner, load sw_sel, then go to SETTLE.
  - SETTLE: the counter runs for SW_SETTLE cycles, then go to OCCUPIED.
  - OCCUPIED: go[owner] = 1 and the timeout counter runs.
    - Owner clear rise -> clear pending[owner], set rr_ptr = owner+1 (wrapping), go to IDLE.
    - Counter reaches TIMEOUT_CYCLES -> ALARM.
  - ALARM: all go = 0, alarm = 1, sw_sel held. Only rst exits.
- Clear rise from a non-owner while busy: set fault; no other effect.
- Clear rise in IDLE: ignored.

## Timing
- Reset values: go all 1, sw_sel 0, busy 0, alarm 0, fault 0. Also pending 0, rr_ptr 0, filters 0, state IDLE.
- Sensor latency: raw edge to rise pulse = 2 + DEB_CYCLES cycles when the input is stable.
- Rise pulse -> pending set on the next edge. With state IDLE, that train's go falls on the same edge.
- IDLE with a pending request -> SETTLE on the next edge; sw_sel and busy update on that edge.
- go[owner] rises exactly SW_SETTLE cycles after entering SETTLE.
- Owner clear rise -> IDLE, busy = 0 on the next edge. A new grant can follow one cycle later, so the minimum gap between grants is 1 IDLE cycle.
- Simultaneous events:
  - Owner clear and another approach in the same cycle: the release is processed and the new pending bit is set. The newcomer competes in the following IDLE cycle.
  - Multiple approach rises in one cycle: all set pending. Round-robin resolves them.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1). The counter saturates and does not wrap.
- rst mid-operation:
  - All state returns to reset values and the owner is forgotten.
  - A sensor held high through reset re-debounces from 0. It produces a fresh rise after 2 + DEB_CYCLES cycles and re-requests.

## Structure
- Package track_pkg holds:
  - the state enum (IDLE, SETTLE, OCCUPIED, ALARM);
  - the default constants for DEB_CYCLES, SW_SETTLE and TIMEOUT_CYCLES;
  - a function computing the next round-robin index.
- One sub-module, sensor_debounce (synchronizer, counter, filtered output and rise pulse), instantiated 2*N_TRAINS times.
- The top level holds the arbiter FSM, pending/rr_ptr registers, the counters and the output registers.

## Test plan
- Single request: train 2 approach held high (N=4, DEB=4, SETTLE=8).
  - go[2]=0 at cycle 7 after the edge; sw_sel=2 and busy=1 next cycle; go[2]=1 eight cycles later.
  - clear[2] pulse -> busy=0 and go[2]=1 held.
- Round-robin: trains 0, 1 and 3 request together. Grants occur in the order 0, 1, 3. After 3 releases, a new request from 0 wins over a later request from 1.
- Glitch rejection: approach[1] high for 3 cycles -> no pending and go[1] stays 1. High for 6 cycles -> request accepted.
- Timeout: the owner never clears, with TIMEOUT_CYCLES=16.
  - alarm=1 and all go=0 after 16 OCCUPIED cycles.
  - State persists until rst, then all outputs return to reset values.
- Fault and simultaneity:
  - Non-owner clear while busy -> fault=1, owner keeps go=1.
  - Owner clear in the same cycle as a new approach -> release, then the newcomer is granted after 1 IDLE cycle.
- Reset mid-SETTLE with approach still held -> outputs reset immediately. The request re-arrives 6 cycles after rst falls and is re-granted.
